// File: rtl/line_centroid_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_centroid_tracker_pkg
// Purpose  : Shared geometry, datapath widths and FSM encoding for the
//            line centroid tracker and its divider.
// Revision : 1.0 - initial release
// ============================================================================
package line_centroid_tracker_pkg;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int COL_W = 9;
  localparam int ROW_W = $clog2(IMG_H) + 1;
  localparam int SUM_W = 15;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DIVIDE  = 2'd2,
    ST_PUBLISH = 2'd3
  } state_e;

  // Midpoint of a dark span, truncating.
  function automatic logic [COL_W-1:0] span_center(input logic [COL_W-1:0] a,
                                                   input logic [COL_W-1:0] b);
    logic [COL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COL_W:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_centroid_tracker_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_15x7
// Purpose  : 15-cycle restoring divider (15-bit / 7-bit) with start/done
//            handshake and synchronous abort.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_15x7
  import line_centroid_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             done_o,
  output logic [SUM_W-1:0] quotient_o
);

  localparam logic [3:0] c_last_iter = 4'(SUM_W - 1);

  logic             busy_q;
  logic             done_q;
  logic [3:0]       iter_q;
  logic [SUM_W-1:0] quot_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] divisor_q;

  logic [CNT_W:0]   w_rem_sh;
  logic             w_ge;
  logic [SUM_W-1:0] quot_d;
  logic [CNT_W-1:0] rem_d;

  // The restored remainder is always below the divisor, so 7-bit wrap is exact.
  always_comb begin
    w_rem_sh = {rem_q, quot_q[SUM_W-1]};
    w_ge     = (w_rem_sh >= {1'b0, divisor_q});
    rem_d    = w_ge ? (w_rem_sh[CNT_W-1:0] - divisor_q) : w_rem_sh[CNT_W-1:0];
    quot_d   = {quot_q[SUM_W-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      iter_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        busy_q <= 1'b0;
      end else if (start_i) begin
        busy_q    <= 1'b1;
        iter_q    <= '0;
        quot_q    <= dividend_i;
        rem_q     <= '0;
        divisor_q <= divisor_i;
      end else if (busy_q) begin
        quot_q <= quot_d;
        rem_q  <= rem_d;
        iter_q <= iter_q + 4'd1;
        if (iter_q == c_last_iter) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quot_q;

endmodule
`default_nettype wire

// File: rtl/line_centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module   : line_centroid_tracker
// Purpose  : Averages the centers of dark spans over a band of rows in a
//            thresholded camera frame and publishes the line column per frame.
//            Optional macro LINE_ROWOUT_EN adds per-row outputs.
// Revision : 1.0 - initial release
// ============================================================================
module line_centroid_tracker #(
  parameter int   IMG_W      = line_centroid_tracker_pkg::IMG_W,
  parameter int   BAND_START = 176,
  parameter int   BAND_ROWS  = 64,
  parameter int   MIN_WIDTH  = 3,
  parameter logic DARK_LEVEL = 1'b1
) (
  input  logic       cam_pclk,
  input  logic       nreset,
  input  logic       in_frame,
  input  logic       pix_valid,
  input  logic       pix_bit,
  output logic [8:0] line_pos,
  output logic       line_found,
  output logic       result_valid,
`ifdef LINE_ROWOUT_EN
  output logic [8:0] row_pos,
  output logic       row_found,
  output logic       row_valid,
`endif
  output logic       frame_overrun
);
  import line_centroid_tracker_pkg::*;

  localparam logic [COL_W-1:0] c_last_col = COL_W'(IMG_W - 1);

  logic             in_frame_q;
  state_e           state_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] first_q;
  logic [COL_W-1:0] last_q;
  logic             any_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic [COL_W-1:0] line_pos_q;
  logic             line_found_q;
  logic             result_valid_q;
  logic             overrun_q;

  logic             w_rise, w_fall, w_pix, w_dark, w_row_end;
  logic             w_in_band, w_any, w_row_hit;
  logic [COL_W-1:0] w_first, w_last, w_center, w_quot_sat;
  logic [COL_W:0]   w_span;
  logic             w_div_start, w_div_abort, w_div_done;
  logic [SUM_W-1:0] w_quot;

  // Row-end decisions must include the pixel arriving this cycle.
  always_comb begin
    w_rise      = in_frame & ~in_frame_q;
    w_fall      = ~in_frame & in_frame_q;
    w_pix       = (state_q == ST_ACCUM) & in_frame & pix_valid;
    w_dark      = w_pix & (pix_bit == DARK_LEVEL);
    w_row_end   = w_pix & (col_q == c_last_col);
    w_in_band   = (int'(row_q) >= BAND_START) && (int'(row_q) < BAND_START + BAND_ROWS);
    w_any       = any_q | w_dark;
    w_first     = any_q ? first_q : col_q;
    w_last      = w_dark ? col_q : last_q;
    w_span      = {1'b0, w_last} - {1'b0, w_first} + (COL_W+1)'(1);
    w_row_hit   = w_row_end & w_in_band & w_any & (int'(w_span) >= MIN_WIDTH);
    w_center    = span_center(w_first, w_last);
    w_div_start = (state_q == ST_ACCUM) & w_fall & (cnt_q != '0);
    w_div_abort = (state_q == ST_DIVIDE) & w_rise;
    w_quot_sat  = (w_quot > SUM_W'(IMG_W - 1)) ? c_last_col : w_quot[COL_W-1:0];
  end

  always_ff @(posedge cam_pclk or negedge nreset) begin
    if (!nreset) begin
      in_frame_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      first_q    <= '0;
      last_q     <= '0;
      any_q      <= 1'b0;
      sum_q      <= '0;
      cnt_q      <= '0;
    end else begin
      in_frame_q <= in_frame;
      if (w_rise) begin
        col_q   <= '0;
        row_q   <= '0;
        first_q <= '0;
        last_q  <= '0;
        any_q   <= 1'b0;
        sum_q   <= '0;
        cnt_q   <= '0;
      end else if (w_pix) begin
        if (w_row_end) begin
          col_q   <= '0;
          first_q <= '0;
          last_q  <= '0;
          any_q   <= 1'b0;
          if (row_q != '1) row_q <= row_q + ROW_W'(1);
          if (w_row_hit) begin
            sum_q <= sum_q + SUM_W'(w_center);
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end else begin
          col_q <= col_q + COL_W'(1);
          if (w_dark) begin
            if (!any_q) first_q <= col_q;
            last_q <= col_q;
            any_q  <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge cam_pclk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= ST_IDLE;
      line_pos_q     <= '0;
      line_found_q   <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE:   if (w_rise) state_q <= ST_ACCUM;
        ST_ACCUM:  if (w_fall) state_q <= ST_DIVIDE;
        ST_DIVIDE: begin
          if (w_rise) begin
            overrun_q <= 1'b1;
            state_q   <= ST_ACCUM;
          end else if ((cnt_q == '0) || w_div_done) begin
            state_q <= ST_PUBLISH;
          end
        end
        ST_PUBLISH: begin
          line_pos_q     <= (cnt_q == '0) ? '0 : w_quot_sat;
          line_found_q   <= (cnt_q != '0);
          result_valid_q <= 1'b1;
          state_q        <= w_rise ? ST_ACCUM : ST_IDLE;
        end
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  seq_divider_15x7 u_div (
    .clk        (cam_pclk),
    .rst_n      (nreset),
    .start_i    (w_div_start),
    .abort_i    (w_div_abort),
    .dividend_i (sum_q),
    .divisor_i  (cnt_q),
    .done_o     (w_div_done),
    .quotient_o (w_quot)
  );

  assign line_pos      = line_pos_q;
  assign line_found    = line_found_q;
  assign result_valid  = result_valid_q;
  assign frame_overrun = overrun_q;

`ifdef LINE_ROWOUT_EN
  logic [COL_W-1:0] row_pos_q;
  logic             row_found_q;
  logic             row_valid_q;

  always_ff @(posedge cam_pclk or negedge nreset) begin
    if (!nreset) begin
      row_pos_q   <= '0;
      row_found_q <= 1'b0;
      row_valid_q <= 1'b0;
    end else begin
      row_valid_q <= w_row_end & w_in_band;
      if (w_row_end & w_in_band) begin
        row_pos_q   <= w_any ? w_center : '0;
        row_found_q <= w_row_hit;
      end
    end
  end

  assign row_pos   = row_pos_q;
  assign row_found = row_found_q;
  assign row_valid = row_valid_q;
`endif

endmodule
`default_nettype wire
